// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches one 8-word block from pipelined memory into the chosen way, then commits the tag.
// Latency MEM_LAT+8 cycles in FILL plus one TAG cycle; the pipeline is stalled by o_fsm_busy for the whole fill.
module cache_fill_fsm #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_miss_detected,
  input  logic [15:0] i_miss_address,
  input  logic        i_way_sel,
  input  logic        i_mem_data_valid,
  input  logic [15:0] i_mem_data_in,
  output logic        o_fsm_busy,
  output logic        o_mem_read,
  output logic [15:0] o_mem_address,
  output logic [1:0]  o_data_write,
  output logic [7:0]  o_word_enable,
  output logic [15:0] o_data_out,
  output logic        o_write_tag_array,
  output logic        o_fill_done
);

  // The counters and word enables are hard-wired to an 8-word block.
  if (WORDS != 8 || MEM_LAT < 1) begin : g_bad_param
    $error("cache_fill_fsm: WORDS must be 8 and MEM_LAT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_TAG  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_issue_cnt;
  logic [3:0]  w_issue_cnt_nxt;
  logic [2:0]  r_recv_cnt;
  logic [2:0]  w_recv_cnt_nxt;
  logic [15:0] r_base_addr;
  logic [15:0] w_base_addr_nxt;
  logic        r_way_q;
  logic        w_way_q_nxt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= 4'd0;
      r_recv_cnt  <= 3'd0;
      r_base_addr <= 16'd0;
      r_way_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_recv_cnt  <= w_recv_cnt_nxt;
      r_base_addr <= w_base_addr_nxt;
      r_way_q     <= w_way_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_issue_cnt_nxt   = r_issue_cnt;
    w_recv_cnt_nxt    = r_recv_cnt;
    w_base_addr_nxt   = r_base_addr;
    w_way_q_nxt       = r_way_q;
    o_fsm_busy        = 1'b0;
    o_mem_read        = 1'b0;
    o_mem_address     = 16'd0;
    o_data_write      = 2'b00;
    o_word_enable     = 8'd0;
    o_data_out        = 16'd0;
    o_write_tag_array = 1'b0;
    o_fill_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_miss_detected) begin
          w_base_addr_nxt = {i_miss_address[15:4], 4'b0000};
          w_way_q_nxt     = i_way_sel;
          w_issue_cnt_nxt = 4'd0;
          w_recv_cnt_nxt  = 3'd0;
          w_state_nxt     = S_FILL;
        end
      end

      S_FILL: begin
        o_fsm_busy = 1'b1;
        if (r_issue_cnt < 4'd8) begin
          o_mem_read      = 1'b1;
          o_mem_address   = r_base_addr + {11'd0, r_issue_cnt, 1'b0};
          w_issue_cnt_nxt = r_issue_cnt + 4'd1;
        end
        // Returned word goes straight to the array so it is captured on this same edge.
        if (i_mem_data_valid) begin
          o_data_write   = r_way_q ? 2'b10 : 2'b01;
          o_word_enable  = 8'd1 << r_recv_cnt;
          o_data_out     = i_mem_data_in;
          w_recv_cnt_nxt = r_recv_cnt + 3'd1;
          if (r_recv_cnt == 3'd7) begin
            w_state_nxt = S_TAG;
          end
        end
      end

      S_TAG: begin
        o_fsm_busy        = 1'b1;
        o_write_tag_array = 1'b1;
        o_fill_done       = 1'b1;
        w_state_nxt       = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a scheduled pipelined-memory model drives returns and a per-cycle
// expectation derived from the fill timeline (requests, return slots, tag cycle) checks every output.
module tb_cache_fill_fsm;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss;
  logic [15:0] maddr;
  logic        way_sel;
  logic        mvld;
  logic [15:0] mdat;
  logic        busy;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [1:0]  data_write;
  logic [7:0]  word_enable;
  logic [15:0] data_out;
  logic        write_tag;
  logic        fill_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.MEM_LAT(L), .WORDS(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_miss_detected   (miss),
    .i_miss_address    (maddr),
    .i_way_sel         (way_sel),
    .i_mem_data_valid  (mvld),
    .i_mem_data_in     (mdat),
    .o_fsm_busy        (busy),
    .o_mem_read        (mem_read),
    .o_mem_address     (mem_address),
    .o_data_write      (data_write),
    .o_word_enable     (word_enable),
    .o_data_out        (data_out),
    .o_write_tag_array (write_tag),
    .o_fill_done       (fill_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, ".mem_address"}, 32'(mem_address), 32'd0);
    chk({tag, ".data_write"}, 32'(data_write), 32'd0);
    chk({tag, ".word_enable"}, 32'(word_enable), 32'd0);
    chk({tag, ".data_out"}, 32'(data_out), 32'd0);
    chk({tag, ".write_tag"}, 32'(write_tag), 32'd0);
    chk({tag, ".fill_done"}, 32'(fill_done), 32'd0);
  endtask

  // One IDLE cycle with a stray memory valid: nothing may be written or requested.
  task automatic idle_step(input string tag);
    @(posedge clk); #1;
    miss = 1'b0;
    mvld = 1'($urandom);
    mdat = 16'($urandom);
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_read"}, 32'(mem_read), 32'd0);
    chk({tag, ".idle_dw"}, 32'(data_write), 32'd0);
    chk({tag, ".idle_tag"}, 32'(write_tag), 32'd0);
  endtask

  // Cycle 0 is the IDLE cycle with the miss; requests are expected in cycles 1..8, word k
  // returns in cycle k+1+L (+gap_len for k >= gap_word), and TAG follows the last return.
  task automatic run_fill(input string tag, input logic [15:0] addr, input logic way,
                          input int gap_word, input int gap_len, input logic [15:0] dbase,
                          input bit toggle, input int abort_words);
    int          resp[8];
    int          tagc;
    int          w;
    logic [15:0] base;
    logic [15:0] ea;
    base = {addr[15:4], 4'h0};
    for (int k = 0; k < 8; k++) resp[k] = k + 1 + L + ((k >= gap_word) ? gap_len : 0);
    tagc = resp[7] + 1;

    @(posedge clk); #1;
    miss    = 1'b1;
    maddr   = addr;
    way_sel = way;
    mvld    = 1'b1;
    mdat    = 16'($urandom);
    @(negedge clk);
    chk({tag, ".c0_busy"}, 32'(busy), 32'd0);
    chk({tag, ".c0_dw"}, 32'(data_write), 32'd0);

    for (int t = 1; t <= tagc; t++) begin
      @(posedge clk); #1;
      if (abort_words > 0 && t == resp[abort_words-1] + 1) begin
        rst  = 1'b0;
        miss = 1'b0;
        mvld = 1'b0;
        #1;
        check_zero({tag, ".abort"});
        return;
      end
      miss = toggle ? 1'($urandom) : 1'b0;
      if (toggle) begin
        way_sel = 1'($urandom);
        maddr   = 16'($urandom);
      end
      w = -1;
      for (int k = 0; k < 8; k++) if (resp[k] == t) w = k;
      mvld = (w >= 0) || (t == tagc && 1'($urandom));
      mdat = (w >= 0) ? dbase + 16'(w) : 16'($urandom);
      @(negedge clk);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".mem_read"}, 32'(mem_read), (t <= 8) ? 32'd1 : 32'd0);
      if (t <= 8) begin
        ea = base + 16'(2 * (t - 1));
        chk({tag, ".mem_address"}, 32'(mem_address), 32'(ea));
      end
      chk({tag, ".data_write"}, 32'(data_write), (w >= 0) ? (way ? 32'd2 : 32'd1) : 32'd0);
      chk({tag, ".word_enable"}, 32'(word_enable), (w >= 0) ? (32'd1 << w) : 32'd0);
      if (w >= 0) chk({tag, ".data_out"}, 32'(data_out), 32'(dbase + 16'(w)));
      chk({tag, ".write_tag"}, 32'(write_tag), (t == tagc) ? 32'd1 : 32'd0);
      chk({tag, ".fill_done"}, 32'(fill_done), (t == tagc) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    miss    = 1'b1;
    maddr   = 16'h1234;
    way_sel = 1'b1;
    mvld    = 1'b1;
    mdat    = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    @(posedge clk); #1;
    rst  = 1'b1;
    miss = 1'b0;
    mvld = 1'b0;
    idle_step("post_reset");

    run_fill("basic_w0", 16'h1236, 1'b0, 8, 0, 16'h5000, 1'b0, 0);
    idle_step("basic_w0");
    run_fill("way1_data", 16'h2000, 1'b1, 8, 0, 16'hA000, 1'b0, 0);
    idle_step("way1_data");
    run_fill("gapped", 16'h3454, 1'b0, 4, 2, 16'h1100, 1'b0, 0);
    idle_step("gapped");
    run_fill("toggle_wrap", 16'hFFFF, 1'b1, 8, 0, 16'h7700, 1'b1, 0);
    idle_step("toggle_wrap");

    run_fill("abort", 16'h7770, 1'b0, 8, 0, 16'h2200, 1'b0, 3);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      miss = 1'b1;
      mvld = 1'b1;
      @(negedge clk);
      check_zero("abort_hold");
    end
    @(posedge clk); #1;
    rst  = 1'b1;
    miss = 1'b0;
    mvld = 1'b0;
    run_fill("after_abort", 16'h0040, 1'b1, 8, 0, 16'h3300, 1'b0, 0);

    run_fill("b2b_first", 16'h4442, 1'b0, 8, 0, 16'h4400, 1'b0, 0);
    run_fill("b2b_second", 16'h9A9E, 1'b1, 6, 1, 16'h9900, 1'b0, 0);
    idle_step("b2b");

    for (int i = 0; i < 12; i++) begin
      run_fill("rand", 16'($urandom), 1'($urandom), int'($urandom_range(1, 8)),
               int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 0);
      if (1'($urandom)) idle_step("rand");
    end
    idle_step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller that sits directly upstream of the cache data array. On a cache miss it fetches the full 8-word (16-byte) block from a pipelined main memory and writes each returned word into the selected way of the data array. When the block is complete it pulses the tag-array write. Only one fill is in flight at a time; the pipeline stalls on `fsm_busy`.

Parameters:
- `MEM_LAT`, default 4: fixed memory read latency in cycles, request to `mem_data_valid`.
- `WORDS`, default 8: words per block; fixed at 8 to match the data-array word enables.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `miss_detected`  in  1  level; a miss is pending on the current access.
- `miss_address`  in  16  byte address of the missing access.
- `way_sel`  in  1  victim way for this fill (0 = low half, 1 = high half); sampled at fill start.
- `mem_data_valid`  in  1  memory returns one word this cycle.
- `mem_data_in`  in  16  returned word.
- `fsm_busy`  out  1  a fill is in progress; stalls the pipeline.
- `mem_read`  out  1  memory read request this cycle.
- `mem_address`  out  16  byte address of the request.
- `data_write`  out  2  one-hot way write to the data array (bit1 = way1, bit0 = way0).
- `word_enable`  out  8  one-hot word select for the data array.
- `data_out`  out  16  word to write into the data array.
- `write_tag_array`  out  1  one-cycle pulse that commits the tag and valid bit.
- `fill_done`  out  1  one-cycle pulse on the final cycle of a fill.

Behaviour:
- States: `IDLE`, `FILL`, `TAG`. Encoding is free.

Reset (`rst` = 0, asynchronous):
- State goes to `IDLE`; `issue_cnt`, `recv_cnt`, `base_addr` and `way_q` clear to 0.
- All outputs are 0: `fsm_busy`, `mem_read`, `mem_address`, `data_write`, `word_enable`, `data_out`, `write_tag_array`, `fill_done`.
- Reset in any state aborts the fill; no partial tag write occurs.
- Memory is reset by the same reset, so no stale responses arrive after reset.

IDLE:
- When `miss_detected` = 1 at a clock edge:
  - latch `base_addr` = {`miss_address`[15:4], 4'b0000};
  - latch `way_q` = `way_sel`;
  - clear both counters;
  - go to `FILL`.
- `mem_data_valid` is ignored in `IDLE`.
- `fsm_busy` is 0 in `IDLE` (it is not combinationally tied to `miss_detected`).

FILL:
- `fsm_busy` = 1.
- Request issue:
  - `mem_read` = 1 while `issue_cnt` < 8.
  - `mem_address` = `base_addr` + 2·`issue_cnt`, giving 0x0, 0x2, … 0xE offsets.
  - `issue_cnt` increments each cycle a request is issued.
  - This yields 8 back-to-back requests in the first 8 `FILL` cycles.
- Data return, on each `mem_data_valid` = 1:
  - `data_write` = one-hot(`way_q`);
  - `word_enable` = one-hot(`recv_cnt`);
  - `data_out` = `mem_data_in`. This path is combinational so the array captures the word on the same edge.
  - `recv_cnt` increments.
- Without `mem_data_valid`, `data_write` = 0 and `word_enable` = 0.
- Issue and receive can overlap in the same cycle.
- When the 8th word is received (`recv_cnt` = 7 with valid), go to `TAG`.

TAG:
- Lasts exactly one cycle.
- `write_tag_array` = 1, `fill_done` = 1, `fsm_busy` = 1.
- Next state is `IDLE`.
- The cache re-looks-up the access one cycle after `TAG` and hits.

Timing and boundary rules:
- With `MEM_LAT` = L, the fill takes 8 + L cycles in `FILL` plus 1 cycle in `TAG`. For L = 4: 12 cycles in `FILL`, `fill_done` at cycle 13 after entry.
- `miss_detected` while `FILL` or `TAG` is active is ignored; state was latched at start.
- `miss_detected` still high in the first cycle back in `IDLE` starts a new fill. This is the cache's responsibility to avoid.
- Base-address wrap: `base_addr` = 0xFFF0 issues 0xFFF0 … 0xFFFE; no carry beyond 16 bits.
- `mem_data_valid` beyond 8 words cannot occur, because the transition to `TAG` is on the 8th word.
- A stray valid in `TAG` or `IDLE` produces no array write.

Test Plan:
- **Reset mid-fill:** reset held → all outputs 0. Start a fill, then assert `rst` = 0 after 3 words → `IDLE`, no `write_tag_array`; release reset and a new miss at 0x0040 restarts with `mem_address` 0x0040.
- **Basic fill, way 0:** miss at 0x1236, `way_sel` = 0, L = 4 →
  - `mem_address` 0x1230, 0x1232, … 0x123E on 8 consecutive cycles;
  - `data_write` = 2'b01 with `word_enable` 0x01 … 0x80 on returns;
  - `write_tag_array` and `fill_done` pulse once, 13 cycles after the miss edge;
  - `fsm_busy` high for 13 cycles.
- **Way 1 fill with data check:** `way_sel` = 1, memory returns 0xA000 + index → `data_write` = 2'b10 and `data_out` 0xA000 … 0xA007 paired with `word_enable` bits 0 … 7.
- **Gapped returns:** memory inserts 2 idle cycles between words 3 and 4 → no writes during the gap, word 4 lands on `word_enable` 0x10, and `TAG` is delayed by 2 cycles.
- **Miss toggling and wrap:** toggle `miss_detected` and change `way_sel` during `FILL` → no effect. A miss at 0xFFFF → addresses 0xFFF0 … 0xFFFE.
- **Back-to-back misses:** a second miss asserted the cycle after `fill_done` → a new `FILL` starts from `IDLE` with a fresh `base_addr` and zeroed counters.
